// File: rtl/idle_ctrl_unit_if.sv
// Commit-side IDLE handshake between the commit stage, the idle controller and pipeline control.
// IdleCycleCnt exists only when IDLE_CNT_EN is defined.
interface idle_ctrl_unit_if #(
  parameter int PC_W  = 32,
  parameter int INT_W = 13
);
  logic             CmtIdleValid;
  logic [PC_W-1:0]  CmtIdlePc;
  logic             StoreBufEmpty;
  logic [INT_W-1:0] IntPending;
  logic             IdleFlashAble;
  logic             IDleStopAble;
  logic             WakeValid;
  logic [PC_W-1:0]  WakePc;
  logic             IdleBusy;
`ifdef IDLE_CNT_EN
  logic [31:0]      IdleCycleCnt;
`endif

  modport master (
    output CmtIdleValid,
    output CmtIdlePc,
    output StoreBufEmpty,
    output IntPending,
    input  IdleFlashAble,
    input  IDleStopAble,
    input  WakeValid,
    input  WakePc,
    input  IdleBusy
`ifdef IDLE_CNT_EN
    , input IdleCycleCnt
`endif
  );

  modport slave (
    input  CmtIdleValid,
    input  CmtIdlePc,
    input  StoreBufEmpty,
    input  IntPending,
    output IdleFlashAble,
    output IDleStopAble,
    output WakeValid,
    output WakePc,
    output IdleBusy
`ifdef IDLE_CNT_EN
    , output IdleCycleCnt
`endif
  );
endinterface

// File: rtl/idle_ctrl_unit.sv
// IDLE instruction controller: flush, drain the store buffer, hold fetch until an interrupt, then wake.
// Optional IDLE_CNT_EN adds a saturating count of stopped cycles on IdleCycleCnt.
//
// state | meaning
// RUN   | normal execution, waiting for an IDLE commit
// FLUSH | one-cycle pipeline flush request
// DRAIN | waiting for the store buffer to empty
// STOP  | fetch and issue held until an interrupt is pending
// WAKE  | one-cycle redirect to the instruction after the IDLE
module idle_ctrl_unit #(
  parameter int PC_W  = 32,
  parameter int INT_W = 13
) (
  input logic         Clk,
  input logic         Rest,
  idle_ctrl_unit_if.slave bus
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    FLUSH = 3'd1,
    DRAIN = 3'd2,
    STOP  = 3'd3,
    WAKE  = 3'd4
  } state_t;

  state_t           state;
  logic             wake_sticky;
  logic [INT_W-1:0] int_vec;
  logic             int_any;
  logic [PC_W-1:0]  next_pc;

  assign int_vec = bus.IntPending;
  assign int_any = |int_vec;
  assign next_pc = bus.CmtIdlePc + PC_W'(4);

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state             <= RUN;
      wake_sticky       <= 1'b0;
      bus.IdleFlashAble <= 1'b0;
      bus.IDleStopAble  <= 1'b0;
      bus.WakeValid     <= 1'b0;
      bus.WakePc        <= '0;
      bus.IdleBusy      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.CmtIdleValid) begin
            state             <= FLUSH;
            bus.WakePc        <= next_pc;
            bus.IdleFlashAble <= 1'b1;
            bus.IdleBusy      <= 1'b1;
          end
        end
        FLUSH: begin
          state             <= DRAIN;
          bus.IdleFlashAble <= 1'b0;
          if (int_any) wake_sticky <= 1'b1;
        end
        DRAIN: begin
          if (int_any) wake_sticky <= 1'b1;
          // an interrupt arriving together with the drain still skips STOP
          if (bus.StoreBufEmpty) begin
            if (wake_sticky || int_any) begin
              state         <= WAKE;
              bus.WakeValid <= 1'b1;
            end else begin
              state            <= STOP;
              bus.IDleStopAble <= 1'b1;
            end
          end
        end
        STOP: begin
          if (int_any) begin
            state            <= WAKE;
            bus.IDleStopAble <= 1'b0;
            bus.WakeValid    <= 1'b1;
          end
        end
        WAKE: begin
          state         <= RUN;
          bus.WakeValid <= 1'b0;
          bus.IdleBusy  <= 1'b0;
          wake_sticky   <= 1'b0;
        end
        default: begin
          state             <= RUN;
          wake_sticky       <= 1'b0;
          bus.IdleFlashAble <= 1'b0;
          bus.IDleStopAble  <= 1'b0;
          bus.WakeValid     <= 1'b0;
          bus.IdleBusy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef IDLE_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rest) begin
      bus.IdleCycleCnt <= '0;
    end else if (bus.IDleStopAble && (bus.IdleCycleCnt != 32'hFFFF_FFFF)) begin
      bus.IdleCycleCnt <= bus.IdleCycleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/idle_ctrl_unit.md
# idle_ctrl_unit

Commit-side controller for the LoongArch IDLE instruction; sits directly upstream of the pipeline control block and drives its `IdleFlashAble` and `IDleStopAble` inputs. On an IDLE commit it flushes the pipeline and waits for the store buffer to drain. It then holds fetch stopped until an enabled interrupt is pending, and issues a one-cycle wake redirect to the instruction after the IDLE.

## Interface
Parameters:
- `PC_W`, default 32: PC width.
- `INT_W`, default 13: interrupt vector width (ESTAT.IS already masked by ECFG.LIE).

Ports:
- `Clk` in 1: single clock; every register updates on the rising edge.
- `Rest` in 1: reset, synchronous and active-high.
- `CmtIdleValid` in 1: IDLE instruction committed this cycle.
- `CmtIdlePc` in `PC_W`: PC of the committed IDLE; valid with `CmtIdleValid`.
- `StoreBufEmpty` in 1: store buffer and outstanding writes drained.
- `IntPending` in `INT_W`: masked pending interrupts; any set bit is a wake source.
- `IdleFlashAble` out 1: one-cycle pipeline flush request to the control block.
- `IDleStopAble` out 1: level; fetch and issue held while high.
- `WakeValid` out 1: one-cycle wake redirect strobe.
- `WakePc` out `PC_W`: redirect target, `CmtIdlePc + 4`; valid while `WakeValid` is high.
- `IdleBusy` out 1: high in every state except RUN.
- `IdleCycleCnt` out 32: present only with `IDLE_CNT_EN` (see Configuration).

## Operation
- States and encoding: RUN (0), FLUSH (1), DRAIN (2), STOP (3), WAKE (4).
- RUN → FLUSH on `CmtIdleValid`; the `CmtIdlePc + 4` register latches on the same edge.
- FLUSH: `IdleFlashAble` = 1 for exactly this cycle → DRAIN unconditionally.
- DRAIN: wait for `StoreBufEmpty`.
  - When it is seen, go to WAKE if `WakeSticky` is set, else STOP.
- `WakeSticky`:
  - Set by any cycle with `|IntPending` in FLUSH or DRAIN.
  - Cleared on entry to RUN.
- STOP: `IDleStopAble` = 1. Move to WAKE in the cycle after `|IntPending` is sampled high.
- WAKE: `WakeValid` = 1, `IDleStopAble` = 0 → RUN.
- `WakePc` arithmetic: `CmtIdlePc + 4` truncated to `PC_W` bits, so it wraps modulo 2^`PC_W` (0xFFFFFFFC → 0x00000000).
- `CmtIdleValid` outside RUN is ignored; no state or PC change. Bench flags it as a protocol error.
- `IntPending` in RUN has no effect.
- All outputs come from registers; there is no combinational input-to-output path.
- Reset values: state = RUN; `IdleFlashAble`, `IDleStopAble`, `WakeValid`, `IdleBusy`, `WakeSticky` = 0; `WakePc` = 0; `IdleCycleCnt` = 0.
- Reset mid-operation, in any state: the next cycle is RUN with all reset values. No wake pulse and no flush are emitted.

## Timing
- `CmtIdleValid` at cycle T → `IdleFlashAble` at T+1, DRAIN at T+2.
- If `StoreBufEmpty` is high at T+2 → `IDleStopAble` rises at T+3. Minimum IDLE-to-stop latency is 3 cycles.
- `StoreBufEmpty` low for N cycles extends DRAIN by N cycles; there is no timeout.
- `|IntPending` at cycle W in STOP → `WakeValid` = 1 and `IDleStopAble` = 0 at W+1; RUN at W+2.
- A new IDLE commit is accepted at W+2 at the earliest.
- Interrupt during FLUSH or DRAIN with `StoreBufEmpty` high at T+2 → `WakeValid` at T+3. STOP is never entered and `IDleStopAble` never rises.
- `IntPending` and `StoreBufEmpty` rising in the same DRAIN cycle → WAKE; the interrupt counts toward `WakeSticky` in that cycle.
- `IdleFlashAble` and `WakeValid` are never high in the same cycle.

## Configuration
- Macro: `IDLE_CNT_EN`.
- Defined:
  - Port `IdleCycleCnt` exists.
  - Counts +1 for each cycle `IDleStopAble` is high.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by `Rest`; holds its value across wakes.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Basic IDLE: `CmtIdleValid` with PC 0x1C000100, `StoreBufEmpty` = 1, `IntPending` = 0x004 raised 10 cycles after stop.
  - Flush pulse at T+1, stop from T+3.
  - `WakeValid` with `WakePc` 0x1C000104 one cycle after the interrupt; `IDleStopAble` low the same cycle.
- Slow drain: `StoreBufEmpty` held low for 5 cycles after FLUSH → `IDleStopAble` rises at T+8; flush pulse is still a single cycle.
- Early interrupt: `IntPending` = 0x800 pulsed for one cycle during FLUSH, then drained → `WakeValid` at T+3, `IDleStopAble` never high.
- PC wrap: IDLE at 0xFFFFFFFC, then wake → `WakePc` = 0x00000000.
- Reset in STOP: `Rest` asserted for 1 cycle → next cycle all outputs 0, state RUN, no `WakeValid`. A following IDLE sequence behaves as in the basic IDLE case.
- `IDLE_CNT_EN` build: stop held for 20 cycles, twice → `IdleCycleCnt` = 40. Also a second IDLE commit issued during DRAIN → ignored: `WakePc` unchanged and no second flush pulse.
